// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and word geometry for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} dmem_state_t;
  localparam int DMEM_WORD_BYTES = 8;
  localparam int DMEM_DATA_WIDTH = 64;
endpackage

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: single-port 64-bit word RAM with per-byte write enables and registered read
// Ports: clk; addr word index; we write strobe; be byte enables; wdata write word; rdata word read at the previous edge.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       we,
  input  logic [DMEM_WORD_BYTES-1:0] be,
  input  logic [DMEM_DATA_WIDTH-1:0] wdata,
  output logic [DMEM_DATA_WIDTH-1:0] rdata
);
  logic [DMEM_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DMEM_WORD_BYTES; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-side bus responder backed by a byte-maskable word RAM
// Ports: clk, rst_n (async active-low); data_read_in/data_write_in request; data_address_in byte address;
//   data_write_mask_in byte lanes; data_write_value_in write word; hold_in initiator back-pressure;
//   data_read_value_out registered read word; stall_out request outstanding; fault_out illegal-request pulse.
// Optional: define DMEM_RESPONDER_PERF_COUNTERS_EN to add read_count_out / write_count_out.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_read_in,
  input  logic                       data_write_in,
  input  logic [63:0]                data_address_in,
  input  logic [DMEM_WORD_BYTES-1:0] data_write_mask_in,
  input  logic [DMEM_DATA_WIDTH-1:0] data_write_value_in,
  input  logic                       hold_in,
  output logic [DMEM_DATA_WIDTH-1:0] data_read_value_out,
  output logic                       stall_out,
  output logic                       fault_out
`ifdef DMEM_RESPONDER_PERF_COUNTERS_EN
  ,
  output logic [31:0]                read_count_out,
  output logic [31:0]                write_count_out
`endif
);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  dmem_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DMEM_WORD_BYTES-1:0] mask_q;
  logic [DMEM_DATA_WIDTH-1:0] wval_q, ram_q;
  logic wr_q, ok_q;
  logic req, in_range, accept, last;
  logic [63:0] word_idx;
  assign req      = data_read_in | data_write_in;
  assign word_idx = (data_address_in - BASE_ADDR) >> 3;
  // a base-relative address below BASE_ADDR wraps to a huge index and lands out of range
  assign in_range = word_idx[63:ADDR_WIDTH] == '0;
  assign accept   = state == IDLE && req;
  assign last     = state == BUSY && cnt == '0;
  always_comb begin
    state_nxt = accept ? BUSY : last ? DONE : (state == DONE && !hold_in) ? IDLE : state;
    stall_out = rst_n && (accept || state == BUSY);
    fault_out = rst_n && accept && ((data_read_in && data_write_in) || !in_range);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      idx_q               <= '0;
      mask_q              <= '0;
      wval_q              <= '0;
      wr_q                <= 1'b0;
      ok_q                <= 1'b0;
      data_read_value_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= WAIT_LD;
        idx_q  <= word_idx[ADDR_WIDTH-1:0];
        mask_q <= data_write_mask_in;
        wval_q <= data_write_value_in;
        wr_q   <= data_write_in;
        ok_q   <= in_range;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (last && !wr_q) data_read_value_out <= ok_q ? ram_q : '0;
    end
  end
  // the RAM is addressed from the live request in IDLE so its registered word is ready by the first BUSY cycle
  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (clk),
    .addr (state == IDLE ? word_idx[ADDR_WIDTH-1:0] : idx_q),
    .we   (last && wr_q && ok_q),
    .be   (mask_q),
    .wdata(wval_q),
    .rdata(ram_q)
  );
`ifdef DMEM_RESPONDER_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_count_out  <= '0;
      write_count_out <= '0;
    end else if (last) begin
      if (wr_q) write_count_out <= write_count_out + 32'd1;
      else read_count_out <= read_count_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder
module tb_dmem_responder;
  localparam int W = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_read_in = 1'b0, data_write_in = 1'b0, hold_in = 1'b0;
  logic [63:0] data_address_in = '0, data_write_value_in = '0;
  logic [7:0] data_write_mask_in = '0;
  logic [63:0] data_read_value_out;
  logic stall_out, fault_out;
`ifdef DMEM_RESPONDER_PERF_COUNTERS_EN
  logic [31:0] read_count_out, write_count_out;
`endif
  logic [63:0] mdl [1024];
  logic [63:0] exp_q [$];
  int checks = 0, failures = 0, rd_done = 0, wr_done = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W), .BASE_ADDR(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_read_in(data_read_in), .data_write_in(data_write_in),
    .data_address_in(data_address_in), .data_write_mask_in(data_write_mask_in),
    .data_write_value_in(data_write_value_in), .hold_in(hold_in),
    .data_read_value_out(data_read_value_out), .stall_out(stall_out), .fault_out(fault_out)
`ifdef DMEM_RESPONDER_PERF_COUNTERS_EN
    , .read_count_out(read_count_out), .write_count_out(write_count_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // starts in IDLE shortly after a rising edge; returns in IDLE shortly after a rising edge
  task automatic access(input bit rd, input bit wr, input logic [63:0] addr, input logic [7:0] mask,
                        input logic [63:0] val, input int hold);
    logic [63:0] idx;
    logic [63:0] e;
    bit ok, is_rd;
    int n, dc;
    idx = addr >> 3;
    ok = idx < 64'd1024;
    is_rd = rd && !wr;
    n = 0;
    dc = hold > 0 ? hold : 1;
    e = '0;
    data_read_in = rd;
    data_write_in = wr;
    data_address_in = addr;
    data_write_mask_in = mask;
    data_write_value_in = val;
    if (is_rd) exp_q.push_back(ok ? mdl[idx[9:0]] : 64'h0);
    else if (ok) for (int b = 0; b < 8; b++) if (mask[b]) mdl[idx[9:0]][8*b +: 8] = val[8*b +: 8];
    #2;
    check("stall_accept", {63'h0, stall_out}, 64'h1);
    check("fault_accept", {63'h0, fault_out}, {63'h0, (rd && wr) || !ok});
    @(posedge clk); #1;
    check("fault_pulse_end", {63'h0, fault_out}, 64'h0);
    data_address_in = {$urandom, $urandom};
    data_write_value_in = {$urandom, $urandom};
    data_write_mask_in = 8'($urandom);
    while (stall_out && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("latency", 64'(n), 64'(W + 1));
    data_read_in = 1'b0;
    data_write_in = 1'b0;
    if (wr) wr_done++; else rd_done++;
    if (is_rd) e = exp_q.pop_front();
    for (int k = 0; k < dc; k++) begin
      hold_in = k < dc - 1;
      check("done_stall", {63'h0, stall_out}, 64'h0);
      if (is_rd) check("rdata", data_read_value_out, e);
      @(posedge clk); #1;
    end
    hold_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data_read_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", {63'h0, stall_out}, 64'h0);
    check("reset_fault", {63'h0, fault_out}, 64'h0);
    check("reset_rdata", data_read_value_out, 64'h0);
    data_read_in = 1'b0;
    rst_n = 1'b1;
    #1;
    access(0, 1, 64'h10, 8'hFF, 64'h1122334455667788, 0);
    access(1, 0, 64'h10, 8'h00, 64'h0, 0);
    access(0, 1, 64'h18, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 0);
    access(0, 1, 64'h18, 8'b00110011, 64'h0, 0);
    access(1, 0, 64'h18, 8'h00, 64'h0, 0);
    access(1, 0, 64'h10, 8'h00, 64'h0, 3);
    access(0, 1, 64'h10, 8'h00, 64'hDEADBEEFDEADBEEF, 0);
    access(1, 0, 64'h10, 8'h00, 64'h0, 0);
    access(0, 1, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 0);
    access(1, 0, 64'h2000, 8'h00, 64'h0, 0);
    access(0, 1, 64'h2000, 8'hFF, 64'hCAFECAFECAFECAFE, 0);
    access(1, 0, 64'h0, 8'h00, 64'h0, 0);
    access(1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 64'h0, 2);
    for (int i = 0; i < 6; i++) access(0, 1, 64'(8 * (40 + i)), 8'hFF, {$urandom, $urandom}, 0);
    for (int i = 0; i < 6; i++) access(0, 1, 64'(8 * (40 + i)), 8'($urandom), {$urandom, $urandom}, 0);
    for (int i = 0; i < 6; i++) access(1, 0, 64'(8 * (40 + i)), 8'h00, 64'h0, i % 3);
    access(0, 1, 64'h20, 8'hFF, 64'h5555555555555555, 0);
    access(1, 0, 64'h10, 8'h00, 64'h0, 0);
    data_write_in = 1'b1;
    data_address_in = 64'h20;
    data_write_mask_in = 8'hFF;
    data_write_value_in = 64'hAA;
    @(posedge clk); #1;
    check("busy_before_reset", {63'h0, stall_out}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("stall_in_reset", {63'h0, stall_out}, 64'h0);
    check("rdata_in_reset", data_read_value_out, 64'h0);
    data_write_in = 1'b0;
    rd_done = 0;
    wr_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("idle_after_reset", {63'h0, stall_out}, 64'h0);
    access(1, 0, 64'h20, 8'h00, 64'h0, 0);
    access(0, 1, 64'h28, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 0);
    access(1, 1, 64'h28, 8'h0F, 64'h1234567812345678, 0);
    access(0, 1, 64'h30, 8'hF0, 64'h0, 1);
    access(1, 0, 64'h28, 8'h00, 64'h0, 0);
    access(1, 0, 64'h18, 8'h00, 64'h0, 0);
`ifdef DMEM_RESPONDER_PERF_COUNTERS_EN
    check("read_count", {32'h0, read_count_out}, 64'(rd_done));
    check("write_count", {32'h0, write_count_out}, 64'(wr_done));
    check("read_count_abs", {32'h0, read_count_out}, 64'd3);
    check("write_count_abs", {32'h0, write_count_out}, 64'd3);
`endif
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
